bmatch_vec_driver: RTL and testbench

BMATCH_VEC_DRIVER -- requirements
Module: bmatch_vec_driver

---
 rtl/bmatch_drv_pkg.sv | 27 ++
 rtl/bmatch_misr.sv | 34 +++
 rtl/bmatch_vec_driver.sv | 129 ++++++++++++
 tb/tb_bmatch_vec_driver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmatch_drv_pkg.sv
// Shared widths, FSM states and polynomial taps for the matcher vector driver.
// The tap positions assume the default 36-bit stimulus and 16-bit signature.
package bmatch_drv_pkg;

    localparam int VEC_W_DEF  = 36;
    localparam int RESP_W_DEF = 7;
    localparam int SIG_W_DEF  = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Stimulus LFSR: shift left, new bit0 = q[35] ^ q[24]
    localparam int LFSR_TAP_HI = 35;
    localparam int LFSR_TAP_LO = 24;

    // Signature MISR feedback: m[15] ^ m[14] ^ m[12] ^ m[3]
    localparam int MISR_TAP_0 = 15;
    localparam int MISR_TAP_1 = 14;
    localparam int MISR_TAP_2 = 12;
    localparam int MISR_TAP_3 = 3;

endpackage

// File: rtl/bmatch_misr.sv
// Multiple-input signature register compacting matcher responses.
// clear has priority over en so a new run always starts from a zero signature.
module bmatch_misr
    import bmatch_drv_pkg::*;
#(
    parameter int SIG_W  = SIG_W_DEF,
    parameter int RESP_W = RESP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [RESP_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                   input logic [RESP_W-1:0] d);
        logic fb;
        fb = m[MISR_TAP_0] ^ m[MISR_TAP_1] ^ m[MISR_TAP_2] ^ m[MISR_TAP_3];
        return {m[SIG_W-2:0], fb} ^ SIG_W'(d);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/bmatch_vec_driver.sv
// Drives LFSR stimulus into a combinational matcher and compacts its responses
// into a MISR signature; one vector per cycle, response captured one cycle later.
module bmatch_vec_driver
    import bmatch_drv_pkg::*;
#(
    parameter int VEC_W  = VEC_W_DEF,
    parameter int RESP_W = RESP_W_DEF,
    parameter int SIG_W  = SIG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [VEC_W-1:0]  seed,
    input  logic [CNT_W-1:0]  num_vec,
    output logic [VEC_W-1:0]  vec_o,
    output logic              vec_valid_o,
    input  logic [RESP_W-1:0] resp_i,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [VEC_W-1:0]   lfsr;
    logic [VEC_W-1:0]   seed_eff;
    logic [VEC_W-1:0]   vec_r;
    logic [CNT_W-1:0]   num_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [RESP_W-1:0]  resp_p0;
    logic               vld_p0;
    logic               accept;
    logic               last_vec;

    function automatic logic [VEC_W-1:0] lfsr_step(input logic [VEC_W-1:0] q);
        return {q[VEC_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    assign seed_eff = (seed == '0) ? VEC_W'(1) : seed;
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_vec = (cnt_r == num_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        vec_valid_o = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_nxt = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                vec_valid_o = 1'b1;
                if (last_vec) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stimulus stage: vec_o holds the vector for the current RUN cycle while
    // lfsr already holds the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr   <= '0;
            vec_r  <= '0;
            cnt_r  <= '0;
            num_r  <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= (state == RUN);
            if (accept) begin
                num_r <= num_vec;
                if (num_vec == '0) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= CNT_W'(1);
                    vec_r <= seed_eff;
                    lfsr  <= lfsr_step(seed_eff);
                end
            end else if ((state == RUN) && !last_vec) begin
                vec_r <= lfsr;
                lfsr  <= lfsr_step(lfsr);
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Response stage: capture the matcher output for the vector just presented
    always_ff @(posedge clk) begin
        resp_p0 <= resp_i;
    end

    bmatch_misr #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (vld_p0),
        .din   (resp_p0),
        .sig   (signature)
    );

    assign vec_o   = vec_r;
    assign vec_cnt = cnt_r;

endmodule

// File: tb/tb_bmatch_vec_driver.sv
// Scoreboard bench for bmatch_vec_driver with a behavioural matcher on resp_i.
module tb_bmatch_vec_driver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [35:0] seed;
    logic [15:0] num_vec;
    logic [35:0] vec_o;
    logic        vec_valid_o;
    logic [6:0]  resp_i;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] vec_cnt;

    bit          resp_mode;
    logic [6:0]  resp_const;

    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];
    int          n_cmp;
    int          n_err;

    bmatch_vec_driver dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .num_vec     (num_vec),
        .vec_o       (vec_o),
        .vec_valid_o (vec_valid_o),
        .resp_i      (resp_i),
        .busy        (busy),
        .done        (done),
        .signature   (signature),
        .vec_cnt     (vec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] matcher(input logic [35:0] v);
        return v[6:0] ^ v[13:7] ^ v[20:14] ^ v[27:21] ^ v[34:28] ^ {6'b0, v[35]};
    endfunction

    assign resp_i = resp_mode ? matcher(vec_o) : resp_const;

    function automatic logic [35:0] m_lfsr(input logic [35:0] q);
        return {q[34:0], q[35] ^ q[24]};
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] m, input logic [6:0] r);
        return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {9'b0, r};
    endfunction

    // Pushes the expected vector stream and returns the expected signature
    task automatic model_run(input logic [35:0] s, input int n, output logic [15:0] sig);
        logic [35:0] q;
        logic [6:0]  r;
        q   = (s == 36'h0) ? 36'h1 : s;
        sig = 16'h0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(q);
            r   = resp_mode ? matcher(q) : resp_const;
            sig = m_misr(sig, r);
            q   = m_lfsr(q);
        end
    endtask

    task automatic run_collect(input logic [35:0] s, input logic [15:0] n, input int pulse_at,
                               output int busy_cycles, output int done_cycle);
        obs_q.delete();
        busy_cycles = 0;
        done_cycle  = -1;
        @(posedge clk); #1;
        seed    = s;
        num_vec = n;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c == pulse_at) begin
                start   = 1'b1;
                seed    = 36'h123456789;
                num_vec = 16'd3;
            end
            @(negedge clk);
            if (busy) busy_cycles++;
            if (vec_valid_o) obs_q.push_back(vec_o);
            if (done) begin
                done_cycle = c;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({vec_valid_o, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got %b want 000", {vec_valid_o, busy, done}); end
        n_cmp++; if (vec_o !== 36'h0) begin n_err++; $display("FAIL reset_vec got %h want 0", vec_o); end
        n_cmp++; if (signature !== 16'h0) begin n_err++; $display("FAIL reset_sig got %h want 0", signature); end
        n_cmp++; if (vec_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", vec_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_count;
        int bc, dc;
        resp_mode  = 1'b0;
        resp_const = 7'h55;
        run_collect(36'h3, 16'd0, -1, bc, dc);
        n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL zc_done_latency got %0d want 0", dc); end
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL zc_valid_count got %0d want 0", obs_q.size()); end
        n_cmp++; if (signature !== 16'h0000) begin n_err++; $display("FAIL zc_sig got %h want 0000", signature); end
        n_cmp++; if (vec_cnt !== 16'd0) begin n_err++; $display("FAIL zc_cnt got %0d want 0", vec_cnt); end
    endtask

    task automatic test_zero_seed;
        int bc, dc;
        logic [15:0] esig;
        logic [35:0] e, o;
        resp_mode  = 1'b0;
        resp_const = 7'h01;
        model_run(36'h0, 2, esig);
        run_collect(36'h0, 16'd2, -1, bc, dc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL zs_vec missing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL zs_vec got %h want %h", o, e); end
            end
        end
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL zs_extra_vec got %0d want 0", obs_q.size()); end
        n_cmp++; if (signature !== 16'h0003) begin n_err++; $display("FAIL zs_sig got %h want 0003", signature); end
        n_cmp++; if (vec_cnt !== 16'd2) begin n_err++; $display("FAIL zs_cnt got %0d want 2", vec_cnt); end
        n_cmp++; if (bc !== 3) begin n_err++; $display("FAIL zs_busy_cycles got %0d want 3", bc); end
        // signature, count and vec_o must hold while sitting in DONE
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({done, vec_valid_o, busy, signature, vec_cnt, vec_o} !== {3'b100, 16'h0003, 16'd2, 36'h2}) begin
            n_err++;
            $display("FAIL zs_done_hold got done=%b vld=%b sig=%h cnt=%0d vec=%h", done, vec_valid_o, signature, vec_cnt, vec_o);
        end
    endtask

    task automatic test_zero_resp;
        int bc, dc;
        resp_mode  = 1'b0;
        resp_const = 7'h00;
        run_collect(36'h1, 16'd1, -1, bc, dc);
        n_cmp++; if (signature !== 16'h0000) begin n_err++; $display("FAIL zr_sig got %h want 0000", signature); end
        n_cmp++; if (bc !== 2) begin n_err++; $display("FAIL zr_busy_cycles got %0d want 2", bc); end
        n_cmp++; if (vec_cnt !== 16'd1) begin n_err++; $display("FAIL zr_cnt got %0d want 1", vec_cnt); end
    endtask

    task automatic test_start_while_busy;
        int bc, dc;
        logic [15:0] esig;
        logic [35:0] e, o;
        resp_mode = 1'b1;
        model_run(36'h0F0F0F0F1, 8, esig);
        run_collect(36'h0F0F0F0F1, 16'd8, 2, bc, dc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL sb_vec missing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL sb_vec got %h want %h", o, e); end
            end
        end
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL sb_extra_vec got %0d want 0", obs_q.size()); end
        n_cmp++; if (vec_cnt !== 16'd8) begin n_err++; $display("FAIL sb_cnt got %0d want 8", vec_cnt); end
        n_cmp++; if (signature !== esig) begin n_err++; $display("FAIL sb_sig got %h want %h", signature, esig); end
    endtask

    task automatic test_reset_mid_run;
        int bc, dc;
        logic [15:0] esig;
        logic [35:0] e, o;
        resp_mode = 1'b1;
        @(posedge clk); #1;
        seed    = 36'h987654321;
        num_vec = 16'd20;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({vec_valid_o, busy, done, vec_o, signature, vec_cnt} !== 71'h0) begin
            n_err++;
            $display("FAIL mid_reset got vld=%b busy=%b done=%b vec=%h sig=%h cnt=%0d", vec_valid_o, busy, done, vec_o, signature, vec_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_run(36'h13579BDF1, 5, esig);
        run_collect(36'h13579BDF1, 16'd5, -1, bc, dc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL rr_vec missing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL rr_vec got %h want %h", o, e); end
            end
        end
        n_cmp++; if (signature !== esig) begin n_err++; $display("FAIL rr_sig got %h want %h", signature, esig); end
        n_cmp++; if (vec_cnt !== 16'd5) begin n_err++; $display("FAIL rr_cnt got %0d want 5", vec_cnt); end
    endtask

    task automatic test_live_matcher;
        int bc, dc;
        logic [15:0] esig;
        logic [35:0] e, o;
        resp_mode = 1'b1;
        model_run(36'hA5A5A5A5A, 1024, esig);
        run_collect(36'hA5A5A5A5A, 16'd1024, -1, bc, dc);
        n_cmp++; if (dc < 0) begin n_err++; $display("FAIL live_timeout got no done want done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL live_vec missing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL live_vec got %h want %h", o, e); end
            end
        end
        n_cmp++; if (signature !== esig) begin n_err++; $display("FAIL live_sig got %h want %h", signature, esig); end
        n_cmp++; if (vec_cnt !== 16'd1024) begin n_err++; $display("FAIL live_cnt got %0d want 1024", vec_cnt); end
        n_cmp++; if (bc !== 1025) begin n_err++; $display("FAIL live_busy_cycles got %0d want 1025", bc); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        seed       = 36'h0;
        num_vec    = 16'h0;
        resp_mode  = 1'b0;
        resp_const = 7'h00;
        test_reset();
        test_zero_count();
        test_zero_seed();
        test_zero_resp();
        test_start_while_busy();
        test_reset_mid_run();
        test_live_matcher();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
